// File: rtl/path_math_pkg.sv
// Shared constants, quarter-wave Q1.8 sine table and FSM encoding for the path planner.
package path_math_pkg;
  localparam int ANGLE_STEPS  = 13;
  localparam int HEADINGS     = 24;
  localparam int DIST_MAX     = 127;
  localparam int MC_DIR_BIT   = 11;
  localparam int MC_STEPS_LSB = 7;
  localparam int MC_STEPS_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_HEADING,
    ST_SQRT,
    ST_DONE
  } state_e;

  // sin(15*m deg) in Q1.8 for m = 0..6
  function automatic logic [8:0] sin_tab(input logic [2:0] m);
    case (m)
      3'd0:    sin_tab = 9'd0;
      3'd1:    sin_tab = 9'd66;
      3'd2:    sin_tab = 9'd128;
      3'd3:    sin_tab = 9'd181;
      3'd4:    sin_tab = 9'd222;
      3'd5:    sin_tab = 9'd247;
      3'd6:    sin_tab = 9'd256;
      default: sin_tab = 9'd0;
    endcase
  endfunction

  function automatic logic signed [9:0] sin_k(input logic [4:0] k);
    logic [2:0] m;
    logic [8:0] mag;
    logic       mirror;
    logic       neg;
    if (k < 5'd6) begin
      m = k[2:0];          mirror = 1'b0; neg = 1'b0;
    end else if (k < 5'd12) begin
      m = 3'(k - 5'd6);    mirror = 1'b1; neg = 1'b0;
    end else if (k < 5'd18) begin
      m = 3'(k - 5'd12);   mirror = 1'b0; neg = 1'b1;
    end else begin
      m = 3'(k - 5'd18);   mirror = 1'b1; neg = 1'b1;
    end
    mag   = mirror ? sin_tab(3'd6 - m) : sin_tab(m);
    sin_k = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic signed [9:0] cos_k(input logic [4:0] k);
    cos_k = sin_k((k >= 5'd18) ? k - 5'd18 : k + 5'd6);
  endfunction

  function automatic logic [3:0] clamp_angle(input logic [3:0] a);
    clamp_angle = (a > 4'(ANGLE_STEPS - 1)) ? 4'(ANGLE_STEPS - 1) : a;
  endfunction

  function automatic logic [4:0] wrap_heading(input logic [4:0] h);
    wrap_heading = (h >= 5'(HEADINGS)) ? h - 5'(HEADINGS) : h;
  endfunction

  function automatic logic signed [32:0] sx10(input logic signed [9:0] v);
    sx10 = {{23{v[9]}}, v};
  endfunction

  function automatic logic signed [32:0] sx19(input logic signed [18:0] v);
    sx19 = {{14{v[18]}}, v};
  endfunction
endpackage

// File: rtl/path_math_isqrt.sv
// Restoring integer square root: root_o = floor(sqrt(rad_i)), one result bit per clock.
// start_i loads a new radicand (restarting any run); done_o pulses 16 clocks later.
module path_math_isqrt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] rad_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] root_o
);
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [19:0] rem_sh, trial;

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_sh = {rem_q, rad_q[31:30]};
    trial  = {2'b00, root_q, 2'b01};
    if (start_i) begin
      rad_d  = rad_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = {rad_q[29:0], 2'b00};
      if (rem_sh >= trial) begin
        rem_d  = 18'(rem_sh - trial);
        root_d = {root_q[14:0], 1'b1};
      end else begin
        rem_d  = rem_sh[17:0];
        root_d = {root_q[14:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign root_o = root_q;
endmodule

// File: rtl/path_math.sv
// Path planner: polar robot/target positions -> absolute heading and packed move command.
// One job per accepted enable, ~45 clocks; results and done hold until the next accepted enable.
module path_math
  import path_math_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] location,
  input  logic [11:0] target,
  input  logic [4:0]  current_orientation,
  output logic [4:0]  needed_orientation,
  output logic [11:0] move_command,
  output logic        done
);
  state_e             state_q, state_d;
  logic [3:0]         loc_a_q, loc_a_d, tgt_a_q, tgt_a_d;
  logic [7:0]         loc_r_q, loc_r_d, tgt_r_q, tgt_r_d;
  logic [4:0]         cur_q, cur_d, k_q, k_d, best_k_q, best_k_d, needed_q, needed_d;
  logic               conv_q, conv_d, sq_q, sq_d, done_q, done_d;
  logic signed [18:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [33:0] best_p_q, best_p_d;
  logic [11:0]        move_q, move_d;

  logic               accept;
  logic [3:0]         cv_a;
  logic [7:0]         cv_r;
  logic signed [18:0] dxs, dys;
  logic signed [32:0] mul_a0, mul_b0, mul_a1, mul_b1, prod0, prod1;
  logic signed [33:0] proj;
  logic [32:0]        sum_sq;
  logic [31:0]        isq_rad;
  logic               isq_start, isq_busy, isq_done;
  logic [15:0]        isq_root;
  logic               degen;
  logic [4:0]         needed_res;
  logic [12:0]        dist_full;
  logic [6:0]         dist_res;
  logic [5:0]         diff_raw, diff;
  logic               turn_dir;
  logic [3:0]         turn_steps;
  logic [11:0]        move_res;

  assign accept = enable && (state_q == ST_IDLE || state_q == ST_DONE);
  assign cv_a   = conv_q ? loc_a_q : tgt_a_q;
  assign cv_r   = conv_q ? loc_r_q : tgt_r_q;
  // Distance is computed on Q.4 deltas so the squared sum fits the 32-bit root unit.
  assign dxs    = (dx_q + 19'sd8) >>> 4;
  assign dys    = (dy_q + 19'sd8) >>> 4;

  // Two multipliers shared by polar conversion, heading projections and squaring.
  always_comb begin
    mul_a0 = '0;
    mul_b0 = '0;
    mul_a1 = '0;
    mul_b1 = '0;
    case (state_q)
      ST_CONVERT: begin
        mul_a0 = {25'd0, cv_r};
        mul_b0 = sx10(cos_k({1'b0, cv_a}));
        mul_a1 = {25'd0, cv_r};
        mul_b1 = sx10(sin_k({1'b0, cv_a}));
      end
      ST_HEADING: begin
        mul_a0 = sx19(dx_q);
        mul_b0 = sx10(cos_k(k_q));
        mul_a1 = sx19(dy_q);
        mul_b1 = sx10(sin_k(k_q));
      end
      ST_SQRT: begin
        mul_a0 = sx19(dxs);
        mul_b0 = sx19(dxs);
        mul_a1 = sx19(dys);
        mul_b1 = sx19(dys);
      end
      default: ;
    endcase
  end

  assign prod0   = mul_a0 * mul_b0;
  assign prod1   = mul_a1 * mul_b1;
  assign proj    = {prod0[32], prod0} + {prod1[32], prod1};
  assign sum_sq  = prod0 + prod1;
  assign isq_rad = sum_sq[32] ? '1 : sum_sq[31:0];

  path_math_isqrt u_isqrt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .start_i (isq_start),
    .rad_i   (isq_rad),
    .busy_o  (isq_busy),
    .done_o  (isq_done),
    .root_o  (isq_root)
  );

  assign degen      = (dx_q == '0) && (dy_q == '0);
  assign needed_res = degen ? cur_q : best_k_q;
  assign dist_full  = 13'(({16'd0, isq_root} + 32'd8) >> 4);
  assign dist_res   = (dist_full > 13'(DIST_MAX)) ? 7'(DIST_MAX) : dist_full[6:0];
  assign diff_raw   = {1'b0, needed_res} + 6'(HEADINGS) - {1'b0, cur_q};
  assign diff       = (diff_raw >= 6'(HEADINGS)) ? diff_raw - 6'(HEADINGS) : diff_raw;
  assign turn_dir   = diff > 6'(HEADINGS / 2);
  assign turn_steps = turn_dir ? 4'(6'(HEADINGS) - diff) : diff[3:0];

  always_comb begin
    move_res = '0;
    if (!degen) begin
      move_res[MC_DIR_BIT]                   = turn_dir;
      move_res[MC_STEPS_LSB +: MC_STEPS_W]   = turn_steps;
      move_res[MC_STEPS_LSB-1:0]             = dist_res;
    end
  end

  always_comb begin
    state_d   = state_q;
    loc_a_d   = loc_a_q;
    loc_r_d   = loc_r_q;
    tgt_a_d   = tgt_a_q;
    tgt_r_d   = tgt_r_q;
    cur_d     = cur_q;
    k_d       = k_q;
    best_k_d  = best_k_q;
    best_p_d  = best_p_q;
    conv_d    = conv_q;
    sq_d      = sq_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    needed_d  = needed_q;
    move_d    = move_q;
    done_d    = done_q;
    isq_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          loc_a_d = clamp_angle(location[11:8]);
          loc_r_d = location[7:0];
          tgt_a_d = clamp_angle(target[11:8]);
          tgt_r_d = target[7:0];
          cur_d   = wrap_heading(current_orientation);
          conv_d  = 1'b0;
          done_d  = 1'b0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (!conv_q) begin
          dx_d   = $signed(prod0[18:0]);
          dy_d   = $signed(prod1[18:0]);
          conv_d = 1'b1;
        end else begin
          dx_d    = dx_q - $signed(prod0[18:0]);
          dy_d    = dy_q - $signed(prod1[18:0]);
          k_d     = '0;
          state_d = ST_HEADING;
        end
      end
      ST_HEADING: begin
        // Strict compare keeps the lowest k on equal projections.
        if (k_q == '0 || proj > best_p_q) begin
          best_p_d = proj;
          best_k_d = k_q;
        end
        if (k_q == 5'(HEADINGS - 1)) begin
          sq_d    = 1'b0;
          state_d = ST_SQRT;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      ST_SQRT: begin
        isq_start = !sq_q;
        sq_d      = 1'b1;
        if (sq_q && !isq_busy && isq_done) begin
          needed_d = needed_res;
          move_d   = move_res;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      loc_a_q  <= '0;
      loc_r_q  <= '0;
      tgt_a_q  <= '0;
      tgt_r_q  <= '0;
      cur_q    <= '0;
      k_q      <= '0;
      best_k_q <= '0;
      best_p_q <= '0;
      conv_q   <= 1'b0;
      sq_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      needed_q <= '0;
      move_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      loc_a_q  <= loc_a_d;
      loc_r_q  <= loc_r_d;
      tgt_a_q  <= tgt_a_d;
      tgt_r_q  <= tgt_r_d;
      cur_q    <= cur_d;
      k_q      <= k_d;
      best_k_q <= best_k_d;
      best_p_q <= best_p_d;
      conv_q   <= conv_d;
      sq_q     <= sq_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      needed_q <= needed_d;
      move_q   <= move_d;
      done_q   <= done_d;
    end
  end

  assign needed_orientation = needed_q;
  assign move_command       = move_q;
  assign done               = done_q;
endmodule

// File: tb/tb_path_math.sv
// Directed checks of the path planner: headings, turn encoding, distance, saturation,
// input clamping, reset and enable-while-busy handling.
module tb_path_math;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] location = '0;
  logic [11:0] target = '0;
  logic [4:0]  current_orientation = '0;
  logic [4:0]  needed_orientation;
  logic [11:0] move_command;
  logic        done;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  path_math dut (
    .clock               (clock),
    .reset               (reset),
    .enable              (enable),
    .location            (location),
    .target              (target),
    .current_orientation (current_orientation),
    .needed_orientation  (needed_orientation),
    .move_command        (move_command),
    .done                (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [11:0] l, input logic [11:0] t, input logic [4:0] c,
                         output logic clr, output int lat);
    @(negedge clock);
    location = l;
    target = t;
    current_orientation = c;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    clr = done;
    lat = 0;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic check_job(input string tag, input logic [4:0] en, input logic [11:0] em,
                           input int lat);
    int d;
    int de;
    d  = int'(move_command[6:0]);
    de = int'(em[6:0]);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat_le64"}, lat <= 64, 1);
    chk({tag, "_needed"}, needed_orientation, en);
    chk({tag, "_turn"}, move_command[11:7], em[11:7]);
    chk({tag, "_dist_pm1"}, (d >= de - 1) && (d <= de + 1), 1);
  endtask

  initial begin
    logic clr;
    int   lat;

    #2 reset = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_needed", needed_orientation, 0);
    chk("rst_move", move_command, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_no_done", done, 0);

    // 34@15 -> 48@105: heading 135 deg, CCW 8, 59 in
    run_job(12'h122, 12'h730, 5'd1, clr, lat);
    check_job("v1", 5'd9, 12'h43B, lat);
    repeat (5) @(negedge clock);
    chk("v1_hold_done", done, 1);
    chk("v1_hold_turn", move_command[11:7], 5'd8);

    run_job(12'h000, 12'h028, 5'd0, clr, lat);
    chk("v2_done_cleared", clr, 0);
    check_job("v2", 5'd0, 12'h028, lat);

    run_job(12'h000, 12'h628, 5'd18, clr, lat);
    check_job("v3_tie_ccw12", 5'd6, 12'h628, lat);

    run_job(12'h000, 12'h028, 5'd3, clr, lat);
    check_job("v4_cw3", 5'd0, 12'h9A8, lat);

    run_job(12'h0C8, 12'hCC8, 5'd12, clr, lat);
    check_job("v5_sat", 5'd12, 12'h07F, lat);
    chk("v5_dist_exact", move_command[6:0], 7'd127);

    run_job(12'h532, 12'h532, 5'd7, clr, lat);
    check_job("v6_degen", 5'd7, 12'h000, lat);
    chk("v6_move_zero", move_command, 12'h000);

    // angle code 15 behaves as 12 (180 deg)
    run_job(12'h000, 12'hF28, 5'd0, clr, lat);
    check_job("clamp_angle", 5'd12, 12'h628, lat);

    // orientation 27 behaves as 3
    run_job(12'h000, 12'h028, 5'd27, clr, lat);
    check_job("wrap_cur", 5'd0, 12'h9A8, lat);

    // enable while busy, with different inputs, must be ignored
    @(negedge clock);
    location = 12'h000;
    target = 12'h628;
    current_orientation = 5'd0;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    location = 12'h0C8;
    target = 12'hCC8;
    current_orientation = 5'd5;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    lat = 11;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clock);
      lat++;
    end
    check_job("busy_ignore", 5'd6, 12'h328, lat);
    repeat (5) @(negedge clock);
    chk("busy_single_needed", needed_orientation, 5'd6);
    chk("busy_single_move", move_command, 12'h328);

    // reset in the middle of a job aborts it
    @(negedge clock);
    location = 12'h000;
    target = 12'h028;
    current_orientation = 5'd0;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_needed", needed_orientation, 0);
    chk("midrst_move", move_command, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    chk("midrst_no_result", done, 0);

    run_job(12'h000, 12'h628, 5'd18, clr, lat);
    check_job("after_rst", 5'd6, 12'h628, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
